// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding memory bus between the fetch port and the load/store port,
// with data priority, an anti-starvation counter for fetches, and dropping of fetches made stale by a flush.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                inst_req_valid,
  input  logic [ADDR_W-1:0]   inst_req_addr,
  output logic                inst_req_ready,
  output logic                inst_rsp_valid,
  output logic [DATA_W-1:0]   inst_rsp_data,
  input  logic                data_req_valid,
  input  logic                data_req_we,
  input  logic [ADDR_W-1:0]   data_req_addr,
  input  logic [DATA_W-1:0]   data_req_wdata,
  input  logic [DATA_W/8-1:0] data_req_wmask,
  output logic                data_req_ready,
  output logic                data_rsp_valid,
  output logic [DATA_W-1:0]   data_rsp_rdata,
  output logic                mem_req_valid,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata
);
  localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, INST_WAIT, DATA_WAIT} state_t;
  state_t        r_state;
  logic [CW-1:0] r_starve;
  logic          r_drop;
  logic w_idle, w_both, w_force_inst, w_gnt_inst, w_gnt_data, w_hs;
  always_comb begin
    w_idle         = r_state == IDLE;
    w_both         = inst_req_valid & data_req_valid;
    w_force_inst   = STARVE_LIMIT != 0 && r_starve == LIM;
    w_gnt_inst     = w_idle & inst_req_valid & (~data_req_valid | w_force_inst);
    w_gnt_data     = w_idle & data_req_valid & ~w_gnt_inst;
    w_hs           = (w_gnt_inst | w_gnt_data) & mem_req_ready;
    mem_req_valid  = w_gnt_inst | w_gnt_data;
    mem_req_we     = w_gnt_data & data_req_we;
    mem_req_addr   = w_gnt_data ? data_req_addr : w_gnt_inst ? inst_req_addr : '0;
    mem_req_wdata  = w_gnt_data ? data_req_wdata : '0;
    mem_req_wmask  = w_gnt_data ? data_req_wmask : '0;
    inst_req_ready = w_gnt_inst & mem_req_ready;
    data_req_ready = w_gnt_data & mem_req_ready;
    inst_rsp_valid = r_state == INST_WAIT && mem_rsp_valid && !r_drop && !flush;
    inst_rsp_data  = inst_rsp_valid ? mem_rsp_rdata : '0;
    data_rsp_valid = r_state == DATA_WAIT && mem_rsp_valid;
    data_rsp_rdata = data_rsp_valid ? mem_rsp_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_drop   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_state <= w_gnt_inst ? INST_WAIT : DATA_WAIT;
          r_drop  <= w_gnt_inst & flush;
          // starvation is only counted when both ports competed for the grant
          if (w_both) r_starve <= w_gnt_inst ? '0 : r_starve + CW'(r_starve != LIM);
        end
        INST_WAIT: begin
          r_state <= mem_rsp_valid ? IDLE : INST_WAIT;
          r_drop  <= ~mem_rsp_valid & (r_drop | flush);
        end
        DATA_WAIT: if (mem_rsp_valid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assert property (@(posedge clk) disable iff (reset) !(r_state == IDLE && mem_rsp_valid));
endmodule
